// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: 4-entry byte FIFO feeding an 8N1 serializer.
// Latency: register writes land on the next clk edge; start bit drives the cycle after the FIFO pop.
// Backpressure: none on the bus; TXDATA writes into a full FIFO are dropped and flag STATUS.overflow.

// Small synchronous FIFO with combinational head and occupancy count.
// Latency: push visible at head one edge later; pop advances head on the edge.
// Backpressure: push refused when full (judged before any same-cycle pop); pop ignored when empty.
module uart_tx_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_rdy,
  output logic [W-1:0]  head_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Count reaches exactly DEPTH only when its top bit is set.
  assign full     = count[AW];
  assign empty    = (count == '0);
  assign do_push  = push_vld && !full;
  assign do_pop   = pop_rdy && !empty;
  assign head_dat = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_tx_periph (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_sel,
  input  logic        uart_wr_enable,
  input  logic [3:0]  uart_addr,
  input  logic [31:0] uart_wdata,
  output logic [31:0] uart_rdata,
  output logic        uart_tx,
  output logic        tx_irq
);
  localparam logic [3:0]  ADDR_TXDATA = 4'h0;
  localparam logic [3:0]  ADDR_STATUS = 4'h4;
  localparam logic [3:0]  ADDR_BAUD   = 4'h8;
  localparam logic [3:0]  ADDR_CTRL   = 4'hC;
  localparam logic [15:0] BAUD_RST    = 16'd867;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nxt;
  logic [15:0] baud_div;
  logic [15:0] lat_div, lat_div_nxt;
  logic [15:0] bit_cnt, bit_cnt_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shift_q, shift_nxt;
  logic        tx_q, tx_nxt;
  logic        tx_en, irq_en, overflow;
  logic        wr_en, wr_txdata, wr_status, wr_baud, wr_ctrl;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic [2:0]  fifo_count;
  logic        busy, bit_end, can_start;
  logic        unused_wdata;

  assign wr_en     = uart_sel && uart_wr_enable;
  assign wr_txdata = wr_en && (uart_addr == ADDR_TXDATA);
  assign wr_status = wr_en && (uart_addr == ADDR_STATUS);
  assign wr_baud   = wr_en && (uart_addr == ADDR_BAUD);
  assign wr_ctrl   = wr_en && (uart_addr == ADDR_CTRL);

  assign busy         = (state != IDLE);
  assign bit_end      = (bit_cnt == lat_div);
  assign can_start    = tx_en && !fifo_empty;
  assign uart_tx      = tx_q;
  assign tx_irq       = fifo_empty && !busy && irq_en;
  assign unused_wdata = ^uart_wdata[31:16];

  uart_tx_fifo #(.W(8), .AW(2)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (wr_txdata),
    .push_dat (uart_wdata[7:0]),
    .pop_rdy  (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Control registers; an overflow set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_div <= BAUD_RST;
      tx_en    <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_baud) baud_div <= uart_wdata[15:0];
      if (wr_ctrl) begin
        tx_en  <= uart_wdata[0];
        irq_en <= uart_wdata[1];
      end
      if (wr_txdata && fifo_full)         overflow <= 1'b1;
      else if (wr_status && uart_wdata[3]) overflow <= 1'b0;
    end
  end

  // Read mux; deselected or unmapped offsets return zero.
  always_comb begin
    uart_rdata = 32'h0;
    if (uart_sel) begin
      case (uart_addr)
        ADDR_STATUS: uart_rdata = {25'h0, fifo_count, overflow, fifo_empty, fifo_full, busy};
        ADDR_BAUD:   uart_rdata = {16'h0, baud_div};
        ADDR_CTRL:   uart_rdata = {30'h0, irq_en, tx_en};
        default:     uart_rdata = 32'h0;
      endcase
    end
  end

  // Serializer state register; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lat_div <= 16'h0;
      bit_cnt <= 16'h0;
      bit_idx <= 3'd0;
      shift_q <= 8'h0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_nxt;
      lat_div <= lat_div_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift_q <= shift_nxt;
      tx_q    <= tx_nxt;
    end
  end

  // Next-state logic; the line value is derived from where the FSM is going so it is registered.
  always_comb begin
    state_nxt   = state;
    lat_div_nxt = lat_div;
    bit_cnt_nxt = bit_cnt + 16'd1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_q;
    fifo_pop    = 1'b0;
    case (state)
      IDLE: begin
        bit_cnt_nxt = 16'h0;
        if (can_start) begin
          state_nxt   = START;
          fifo_pop    = 1'b1;
          lat_div_nxt = baud_div;
          shift_nxt   = fifo_head;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_cnt_nxt = 16'h0;
          bit_idx_nxt = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_nxt = 16'h0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            shift_nxt   = {1'b0, shift_q[7:1]};
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_nxt = 16'h0;
          if (can_start) begin
            state_nxt   = START;
            fifo_pop    = 1'b1;
            lat_div_nxt = baud_div;
            shift_nxt   = fifo_head;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_periph.sv
module tb_uart_tx_periph;
  logic        clk = 1'b0;
  logic        rst;
  logic        uart_sel;
  logic        uart_wr_enable;
  logic [3:0]  uart_addr;
  logic [31:0] uart_wdata;
  logic [31:0] uart_rdata;
  logic        uart_tx;
  logic        tx_irq;

  int   checks = 0;
  int   errors = 0;
  logic exp_tx[$];

  uart_tx_periph dut (
    .clk            (clk),
    .rst            (rst),
    .uart_sel       (uart_sel),
    .uart_wr_enable (uart_wr_enable),
    .uart_addr      (uart_addr),
    .uart_wdata     (uart_wdata),
    .uart_rdata     (uart_rdata),
    .uart_tx        (uart_tx),
    .tx_irq         (tx_irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    uart_sel = 1'b1; uart_wr_enable = 1'b1; uart_addr = a; uart_wdata = d;
    @(negedge clk);
    uart_sel = 1'b0; uart_wr_enable = 1'b0; uart_addr = 4'h0; uart_wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    uart_sel = 1'b1; uart_addr = a;
    #1 d = uart_rdata;
    uart_sel = 1'b0; uart_addr = 4'h0;
  endtask

  // Reference line model: one entry per clock, start 0, data LSB first, stop 1, each div+1 long.
  task automatic model_frame(input logic [7:0] b, input int div);
    for (int i = 0; i < 10; i++) begin
      logic v;
      v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      repeat (div + 1) exp_tx.push_back(v);
    end
  endtask

  function automatic logic [31:0] status_word(input int cnt, input bit ovf, input bit bsy);
    return 32'(cnt * 16 + (ovf ? 8 : 0) + (cnt == 0 ? 4 : 0) + (cnt == 4 ? 2 : 0) + (bsy ? 1 : 0));
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
    checks++; if (tx_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", tx_irq); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_read(4'h4, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL reset_status: got %h expected %h", d, 32'h4); end
    bus_read(4'h8, d);
    checks++; if (d !== 32'd867) begin errors++; $display("FAIL reset_baud: got %0d expected 867", d); end
    bus_read(4'hC, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", d); end
    bus_read(4'h6, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", d); end
    // Deselected read returns zero even at a live address.
    @(negedge clk);
    uart_sel = 1'b0; uart_addr = 4'h8;
    #1;
    checks++; if (uart_rdata !== 32'h0) begin errors++; $display("FAIL desel_read: got %h expected 0", uart_rdata); end
    // Select without write strobe must not update BAUD_DIV.
    uart_sel = 1'b1; uart_wr_enable = 1'b0; uart_addr = 4'h8; uart_wdata = 32'h5;
    @(negedge clk);
    uart_sel = 1'b0;
    bus_write(4'h5, 32'hFFFF_FFFF);
    bus_read(4'h8, d);
    checks++; if (d !== 32'd867) begin errors++; $display("FAIL no_strobe_write: got %0d expected 867", d); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL idle_tx: got %b expected 1", uart_tx); end
  endtask

  task automatic test_single_frame();
    bus_write(4'hC, 32'h1);
    for (int f = 0; f < 3; f++) begin
      logic [7:0] b;
      int div;
      b   = (f == 0) ? 8'h55 : 8'($urandom_range(0, 255));
      div = (f == 0) ? 3 : (f == 1) ? 0 : int'($urandom_range(1, 4));
      bus_write(4'h8, 32'(div));
      exp_tx.delete();
      model_frame(b, div);
      bus_write(4'h0, {24'h0, b});
      uart_sel = 1'b1; uart_addr = 4'h4;
      #1;
      checks++; if (uart_rdata !== status_word(1, 0, 0)) begin errors++; $display("FAIL frame_pre_status: got %h expected %h", uart_rdata, status_word(1, 0, 0)); end
      foreach (exp_tx[k]) begin
        @(negedge clk); #1;
        checks++; if (uart_tx !== exp_tx[k]) begin errors++; $display("FAIL frame_tx byte=%h div=%0d cyc=%0d: got %b expected %b", b, div, k, uart_tx, exp_tx[k]); end
        checks++; if (uart_rdata[0] !== 1'b1) begin errors++; $display("FAIL frame_busy cyc=%0d: got %b expected 1", k, uart_rdata[0]); end
      end
      @(negedge clk); #1;
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL frame_post_tx: got %b expected 1", uart_tx); end
      checks++; if (uart_rdata !== 32'h4) begin errors++; $display("FAIL frame_post_status: got %h expected 4", uart_rdata); end
      uart_sel = 1'b0; uart_addr = 4'h0;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0]  q[$];
    int          n;
    bit          ovf;
    n = 0; ovf = 0;
    bus_write(4'hC, 32'h0);
    bus_write(4'h8, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      bus_write(4'h0, 32'(i));
      if (n < 4) begin n++; q.push_back(8'(i)); end else ovf = 1;
      bus_read(4'h4, d);
      checks++; if (d !== status_word(n, ovf, 0)) begin errors++; $display("FAIL ovf_status push=%0d: got %h expected %h", i, d, status_word(n, ovf, 0)); end
    end
    bus_write(4'h4, 32'h37);
    bus_read(4'h4, d);
    checks++; if (d !== 32'h4A) begin errors++; $display("FAIL ovf_keep: got %h expected 4a", d); end
    bus_write(4'h4, 32'h8);
    bus_read(4'h4, d);
    checks++; if (d !== 32'h42) begin errors++; $display("FAIL ovf_clear: got %h expected 42", d); end
    // Drain: only the first four bytes may appear on the line.
    exp_tx.delete();
    foreach (q[i]) model_frame(q[i], 0);
    bus_write(4'hC, 32'h1);
    foreach (exp_tx[k]) begin
      @(negedge clk); #1;
      checks++; if (uart_tx !== exp_tx[k]) begin errors++; $display("FAIL drain_tx cyc=%0d: got %b expected %b", k, uart_tx, exp_tx[k]); end
    end
    bus_read(4'h4, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL drain_status: got %h expected 4", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bus_write(4'hC, 32'h0);
    bus_write(4'h8, 32'h1);
    exp_tx.delete();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      bus_write(4'h0, {24'h0, b});
      model_frame(b, 1);
    end
    bus_read(4'h4, d);
    checks++; if (d !== status_word(4, 0, 0)) begin errors++; $display("FAIL b2b_full: got %h expected %h", d, status_word(4, 0, 0)); end
    bus_write(4'hC, 32'h1);
    uart_sel = 1'b1; uart_addr = 4'h4;
    foreach (exp_tx[k]) begin
      @(negedge clk); #1;
      checks++; if (uart_tx !== exp_tx[k]) begin errors++; $display("FAIL b2b_tx cyc=%0d: got %b expected %b", k, uart_tx, exp_tx[k]); end
      checks++; if (uart_rdata[0] !== 1'b1) begin errors++; $display("FAIL b2b_busy cyc=%0d: got %b expected 1", k, uart_rdata[0]); end
    end
    @(negedge clk); #1;
    checks++; if (uart_rdata !== 32'h4) begin errors++; $display("FAIL b2b_post_status: got %h expected 4", uart_rdata); end
    uart_sel = 1'b0; uart_addr = 4'h0;
  endtask

  task automatic test_baud_midframe();
    logic [31:0] d;
    logic [7:0]  b0, b1, b2;
    b0 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    bus_write(4'hC, 32'h0);
    bus_write(4'h8, 32'h1);
    bus_write(4'h0, {24'h0, b0});
    bus_write(4'h0, {24'h0, b1});
    bus_write(4'h0, {24'h0, b2});
    // Frame 0 keeps the divider latched at its start; frame 1 picks up the new one;
    // tx_en drops during frame 1, so b2 stays queued.
    exp_tx.delete();
    model_frame(b0, 1);
    model_frame(b1, 2);
    repeat (5) exp_tx.push_back(1'b1);
    bus_write(4'hC, 32'h1);
    fork
      begin
        foreach (exp_tx[k]) begin
          @(negedge clk); #1;
          checks++; if (uart_tx !== exp_tx[k]) begin errors++; $display("FAIL midframe_tx cyc=%0d: got %b expected %b", k, uart_tx, exp_tx[k]); end
        end
      end
      begin
        repeat (3) @(negedge clk);
        bus_write(4'h8, 32'h2);
        repeat (20) @(negedge clk);
        bus_write(4'hC, 32'h0);
      end
    join
    bus_read(4'h4, d);
    checks++; if (d !== status_word(1, 0, 0)) begin errors++; $display("FAIL midframe_status: got %h expected %h", d, status_word(1, 0, 0)); end
  endtask

  task automatic test_irq_reset();
    logic [31:0] d;
    rst = 1'b1;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst2_tx: got %b expected 1", uart_tx); end
    @(negedge clk);
    rst = 1'b0;
    bus_read(4'h4, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL rst_flush: got %h expected 4", d); end
    bus_write(4'h8, 32'h1);
    bus_write(4'h0, 32'hA5);
    exp_tx.delete();
    model_frame(8'hA5, 1);
    bus_write(4'hC, 32'h3);
    #1;
    checks++; if (tx_irq !== 1'b0) begin errors++; $display("FAIL irq_pending: got %b expected 0", tx_irq); end
    foreach (exp_tx[k]) begin
      @(negedge clk); #1;
      checks++; if (uart_tx !== exp_tx[k]) begin errors++; $display("FAIL irq_tx cyc=%0d: got %b expected %b", k, uart_tx, exp_tx[k]); end
      checks++; if (tx_irq !== 1'b0) begin errors++; $display("FAIL irq_during cyc=%0d: got %b expected 0", k, tx_irq); end
    end
    @(negedge clk); #1;
    checks++; if (tx_irq !== 1'b1) begin errors++; $display("FAIL irq_done: got %b expected 1", tx_irq); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL irq_done_tx: got %b expected 1", uart_tx); end
    // Reset in the middle of a start bit must release the line without waiting for an edge.
    bus_write(4'h0, 32'($urandom_range(0, 255)));
    @(negedge clk); #1;
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL abort_start: got %b expected 0", uart_tx); end
    #2 rst = 1'b1;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b expected 1", uart_tx); end
    checks++; if (tx_irq !== 1'b0) begin errors++; $display("FAIL abort_irq: got %b expected 0", tx_irq); end
    @(negedge clk);
    rst = 1'b0;
    bus_read(4'h4, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL abort_status: got %h expected 4", d); end
    bus_read(4'hC, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL abort_ctrl: got %h expected 0", d); end
  endtask

  initial begin
    rst = 1'b1;
    uart_sel = 1'b0;
    uart_wr_enable = 1'b0;
    uart_addr = 4'h0;
    uart_wdata = 32'h0;
    test_reset();
    test_single_frame();
    test_overflow();
    test_back_to_back();
    test_baud_midframe();
    test_irq_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 SHALL have one clock and reset: clk, rst; rst asynchronous, active-high.
REQ-002 Port clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous active-high reset.
REQ-004 Port uart_sel  input  1  access targets this peripheral this cycle.
REQ-005 Port uart_wr_enable  input  1  write strobe, valid only with uart_sel=1.
REQ-006 Port uart_addr  input  4  byte offset of register.
REQ-007 Port uart_wdata  input  32  store data.
REQ-008 Port uart_rdata  output  32  load data, combinational.
REQ-009 Port uart_tx  output  1  serial line, idle high.
REQ-010 Port tx_irq  output  1  level interrupt: FIFO empty and not busy and CTRL.irq_en.

Function
REQ-011 Register map: 0x0 TXDATA (W), 0x4 STATUS (R/W1C), 0x8 BAUD_DIV (R/W, bits 15:0), 0xC CTRL (R/W, bit0 tx_en, bit1 irq_en); other offsets read 0, writes ignored.
REQ-012 A write takes effect only when uart_sel=1 and uart_wr_enable=1 on a clk edge.
REQ-013 Write to TXDATA pushes uart_wdata[7:0] into a 4-entry FIFO if not full.
REQ-014 Fullness evaluated before same-cycle pop; push when full is dropped, sets STATUS.overflow (bit3) sticky.
REQ-015 STATUS read: bit0 busy, bit1 fifo_full, bit2 fifo_empty, bit3 overflow, bits 6:4 fifo count (0-4), others 0.
REQ-016 Writing STATUS with bit3=1 clears overflow; if overflow set and clear coincide, set wins.
REQ-017 uart_rdata = selected register when uart_sel=1, else 32'h0; zero-extended.
REQ-018 FSM states IDLE, START, DATA, STOP.
REQ-019 IDLE -> START when tx_en=1 and FIFO non-empty; FIFO popped and BAUD_DIV latched on that edge.
REQ-020 Each bit period = latched_div+1 cycles; BAUD_DIV writes mid-frame affect next frame only.
REQ-021 START drives 0 one bit period; DATA drives 8 bits LSB first; STOP drives 1 one bit period.
REQ-022 STOP end: next frame starts immediately (no idle gap) if tx_en=1 and FIFO non-empty, else IDLE.
REQ-023 Clearing tx_en mid-frame completes the current frame, then IDLE.
REQ-024 uart_tx is registered; first START bit appears the cycle after the IDLE->START edge.
REQ-025 busy = 1 in START, DATA, STOP.
REQ-026 FIFO pointers 2 bits wrap modulo 4; count 3 bits.

Reset
REQ-027 On rst: uart_tx=1, FSM IDLE, FIFO empty (count 0), overflow 0, BAUD_DIV=16'd867, CTRL=0, tx_irq=0.
REQ-028 rst mid-frame aborts immediately; uart_tx high asynchronously; queued bytes lost.

Verification
REQ-029 Reset, read 0x4 -> 32'h4; read 0x8 -> 32'd867; uart_tx=1.
REQ-030 BAUD_DIV=3, CTRL=1, TXDATA=0x55 -> uart_tx 0 then 1,0,1,0,1,0,1,0 then 1, each held 4 cycles; busy 40 cycles.
REQ-031 CTRL=0, five TXDATA writes 0x01..0x05 -> STATUS 32'h4A (count 4, full, overflow); write 0x4=8 -> 32'h42.
REQ-032 BAUD_DIV=1, four bytes queued, CTRL=1 -> four back-to-back frames, 20 cycles each, no idle gap; then STATUS=32'h4.
REQ-033 BAUD_DIV=1, CTRL=3, byte 0xA5 -> tx_irq low during frame, high when STOP ends; rst asserted mid-frame -> uart_tx=1 same cycle.
